// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table, FSM state encoding and oversampling default.
// Used by both the transmit and receive controllers.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_W              = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  // clk cycles per oversample tick at 50 MHz, indexed by baud_select
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [2:0] code);
    logic [DIV_W-1:0] div;
    case (code)
      3'd0:    div = 14'd10417;
      3'd1:    div = 14'd2604;
      3'd2:    div = 14'd651;
      3'd3:    div = 14'd326;
      3'd4:    div = 14'd163;
      3'd5:    div = 14'd81;
      3'd6:    div = 14'd54;
      default: div = 14'd27;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle pulse every 'divisor' clocks, restartable by clear.
module uart_tick_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == divisor - 14'd1);
  assign tick   = w_wrap & ~clear;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 14'd1;
    end
  end

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmitter: accepts a byte on Tx_WR and shifts start, data (LSB first),
// optional parity and stop bits onto TxD using 16x oversampled baud ticks.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        baud_select,
  input  logic              Tx_EN,
  input  logic              Tx_WR,
  input  logic [DATA_W-1:0] Tx_DATA,
  output logic              TxD,
  output logic              Tx_BUSY,
  output logic              Tx_DONE
);

  localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       r_state, w_next_state;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_baud;
  logic [OS_W-1:0]   r_os_cnt;
  logic [BIT_W-1:0]  r_bit_idx, w_bit_idx_next;
  logic              r_txd, r_busy, r_done;
  logic              w_txd_next, w_done_next;
  logic              w_accept, w_tick, w_bit_end, w_parity;

  assign w_accept  = Tx_WR & Tx_EN & (r_state == S_IDLE);
  assign w_bit_end = w_tick & (r_os_cnt == OS_W'(OVERSAMPLE - 1));
  assign w_parity  = (^r_data) ^ 1'(PARITY_ODD);

  // Cleared on accept so the first bit period starts exactly at the accept edge.
  uart_tick_gen u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .divisor (baud_divisor(r_baud)),
    .tick    (w_tick)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_done_next    = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_START;
      S_START:  if (w_bit_end) begin
                  w_next_state   = S_DATA;
                  w_bit_idx_next = '0;
                end
      S_DATA:   if (w_bit_end) begin
                  if (r_bit_idx == BIT_W'(DATA_W - 1))
                    w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  else
                    w_bit_idx_next = r_bit_idx + 1'b1;
                end
      S_PARITY: if (w_bit_end) w_next_state = S_STOP;
      S_STOP:   if (w_bit_end) begin
                  w_next_state = S_IDLE;
                  w_done_next  = 1'b1;
                end
      default:  w_next_state = S_IDLE;
    endcase

    // Line level is decoded from the next state so TxD stays a plain register.
    case (w_next_state)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = r_data[w_bit_idx_next];
      S_PARITY: w_txd_next = w_parity;
      default:  w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_data    <= '0;
      r_baud    <= '0;
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
      r_busy    <= (w_next_state != S_IDLE);
      r_done    <= w_done_next;
      if (w_accept) begin
        r_data   <= Tx_DATA;
        r_baud   <= baud_select;
        r_os_cnt <= '0;
      end else if (w_bit_end) begin
        r_os_cnt <= '0;
      end else if (w_tick) begin
        r_os_cnt <= r_os_cnt + 1'b1;
      end
    end
  end

  assign TxD     = r_txd;
  assign Tx_BUSY = r_busy;
  assign Tx_DONE = r_done;

endmodule
